reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/reg_write_arbiter_dff_bank.sv | 30 +++
 rtl/reg_write_arbiter.sv | 107 ++++++++++
 tb/tb_reg_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the round-robin register write arbiter.
package reg_arb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;
  localparam int IDW       = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/reg_write_arbiter_dff_bank.sv
// WIDTH-bit storage register with async reset, sync clear (dominant) and load enable.
module dff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  // Complement taken from the register itself so it tracks q even while in reset.
  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester per cycle a write into a shared register.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qn,
  output logic                  wr_done,
  output logic [IDW-1:0]        last_id
);

  // Handshake: req is a level; a high gnt bit means that requester owns this
  // cycle and its wdata slot is written at the following edge unless clr is high.

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic             wr_done_q, wr_done_d;
  logic             load;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic [WIDTH-1:0] wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_id_q <= IDW'(NREQ - 1);
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_id_q <= last_id_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Search upward from last_id+1; the final offset wraps onto the current
  // winner, which is skipped while in GRANT so nobody wins twice in a row.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last_id_q + IDW'(i);
      if (!found && req[idx] && !(state_q == GRANT && i == NREQ)) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    last_id_d = last_id_q;
    wr_done_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!clr && found) begin
          state_d    = GRANT;
          gnt_d[win] = 1'b1;
          last_id_d  = win;
        end
      end
      GRANT: begin
        load      = !clr;
        wr_done_d = !clr;
        if (!clr && found) begin
          gnt_d[win] = 1'b1;
          last_id_d  = win;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_id_q still names the granted requester at the write edge.
  assign wr_data = wdata[int'(last_id_q)*WIDTH +: WIDTH];

  dff_bank #(.WIDTH(WIDTH)) u_dff_bank (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (load),
    .d    (wr_data),
    .q    (q),
    .qn   (qn)
  );

  assign gnt     = gnt_q;
  assign wr_done = wr_done_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        clr;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qn;
  logic        wr_done;
  logic [1:0]  last_id;

  int vectors;
  int miscompares;

  // Reference model: a granted requester id waits in pend_q until the next edge writes it.
  logic [1:0] pend_q[$];
  logic [7:0] m_q;
  logic [3:0] m_gnt;
  logic       m_done;
  int         m_last;

  reg_write_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .clr     (clr),
    .gnt     (gnt),
    .q       (q),
    .qn      (qn),
    .wr_done (wr_done),
    .last_id (last_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    pend_q.delete();
    m_q    = 8'h00;
    m_gnt  = 4'b0000;
    m_done = 1'b0;
    m_last = 3;
  endtask

  task automatic model_step();
    int win;
    int pend;
    win  = -1;
    pend = -1;
    if (pend_q.size() > 0) pend = int'(pend_q.pop_front());
    if (clr) begin
      m_q    = 8'h00;
      m_done = 1'b0;
      m_gnt  = 4'b0000;
    end else begin
      m_done = (pend >= 0);
      if (pend >= 0) m_q = wdata[pend*8 +: 8];
      for (int off = 1; off <= 4; off++) begin
        int id;
        id = (m_last + off) % 4;
        if (win < 0 && id != pend && req[id]) win = id;
      end
      if (win >= 0) begin
        m_last = win;
        m_gnt  = 4'b0000;
        m_gnt[win] = 1'b1;
        pend_q.push_back(2'(win));
      end else begin
        m_gnt = 4'b0000;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = '0;
    clr   = 1'b0;
    wdata = '0;
    model_reset();
    #3;
    vectors++;
    if ({gnt, q, qn, wr_done, last_id} !== {4'b0000, 8'h00, 8'hFF, 1'b0, 2'd3}) begin
      miscompares++;
      $display("FAIL reset_hold: got gnt=%b q=%h qn=%h done=%b id=%0d, need 0000 00 ff 0 3",
               gnt, q, qn, wr_done, last_id);
    end
    @(negedge clk);
    rst = 1'b0;
    cycle();
    vectors++;
    if ({gnt, q, qn, wr_done, last_id} !== {4'b0000, 8'h00, 8'hFF, 1'b0, 2'd3}) begin
      miscompares++;
      $display("FAIL reset_release: got gnt=%b q=%h qn=%h done=%b id=%0d, need 0000 00 ff 0 3",
               gnt, q, qn, wr_done, last_id);
    end
  endtask

  task automatic test_single_write();
    logic [3:0] exp_g[2];
    logic [7:0] exp_v[2];
    logic       exp_d[2];
    exp_g = '{4'b0010, 4'b0000};
    exp_v = '{8'h00, 8'hA5};
    exp_d = '{1'b0, 1'b1};
    wdata = 32'h11_22_A5_33;
    req   = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      cycle();
      req = 4'b0000;
      vectors++;
      if ({gnt, q, qn, wr_done, last_id} !== {exp_g[k], exp_v[k], ~exp_v[k], exp_d[k], 2'd1} ||
          {gnt, q, wr_done} !== {m_gnt, m_q, m_done}) begin
        miscompares++;
        $display("FAIL single_write[%0d]: got gnt=%b q=%h qn=%h done=%b id=%0d, need %b %h %h %b 1",
                 k, gnt, q, qn, wr_done, last_id, exp_g[k], exp_v[k], ~exp_v[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g[5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_dut();
    wdata = {$urandom_range(255,0), $urandom_range(255,0), $urandom_range(255,0), $urandom_range(255,0)};
    wdata[7:0] = 8'hC3;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      vectors++;
      if (gnt !== exp_g[k] || {q, qn, wr_done, last_id} !== {m_q, ~m_q, m_done, 2'(m_last)}) begin
        miscompares++;
        $display("FAIL contention[%0d]: got gnt=%b q=%h done=%b id=%0d, need %b %h %b %0d",
                 k, gnt, q, wr_done, last_id, exp_g[k], m_q, m_done, m_last);
      end
    end
    req = 4'b0000;
    cycle();
    vectors++;
    if ({gnt, q, wr_done} !== {4'b0000, 8'hC3, 1'b1}) begin
      miscompares++;
      $display("FAIL contention_drain: got gnt=%b q=%h done=%b, need 0000 c3 1", gnt, q, wr_done);
    end
  endtask

  task automatic test_masking();
    logic [3:0] exp_g[4];
    exp_g = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
    wdata[23:16] = 8'h5E;
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      cycle();
      vectors++;
      if (gnt !== exp_g[k] || {q, qn, wr_done, last_id} !== {m_q, ~m_q, m_done, 2'(m_last)}) begin
        miscompares++;
        $display("FAIL masking[%0d]: got gnt=%b q=%h done=%b id=%0d, need %b %h %b %0d",
                 k, gnt, q, wr_done, last_id, exp_g[k], m_q, m_done, m_last);
      end
    end
    req = 4'b0000;
    cycle();
  endtask

  task automatic test_clr_grant();
    wdata = 32'h3C_00_77_00;
    req   = 4'b0010;
    cycle();
    req   = 4'b1000;
    cycle();
    req   = 4'b0000;
    vectors++;
    if ({gnt, q, last_id} !== {4'b1000, 8'h77, 2'd3}) begin
      miscompares++;
      $display("FAIL clr_setup: got gnt=%b q=%h id=%0d, need 1000 77 3", gnt, q, last_id);
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    vectors++;
    if ({gnt, q, qn, wr_done, last_id} !== {4'b0000, 8'h00, 8'hFF, 1'b0, 2'd3}) begin
      miscompares++;
      $display("FAIL clr_grant: got gnt=%b q=%h qn=%h done=%b id=%0d, need 0000 00 ff 0 3",
               gnt, q, qn, wr_done, last_id);
    end
    cycle();
    vectors++;
    if ({gnt, q, wr_done} !== {4'b0000, 8'h00, 1'b0} || {gnt, q, wr_done} !== {m_gnt, m_q, m_done}) begin
      miscompares++;
      $display("FAIL clr_after: got gnt=%b q=%h done=%b, need 0000 00 0", gnt, q, wr_done);
    end
  endtask

  task automatic test_async_reset();
    wdata = 32'h00_44_11_00;
    req   = 4'b0010;
    cycle();
    req   = 4'b0100;
    cycle();
    req   = 4'b0000;
    vectors++;
    if ({gnt, q} !== {4'b0100, 8'h11}) begin
      miscompares++;
      $display("FAIL async_setup: got gnt=%b q=%h, need 0100 11", gnt, q);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({gnt, q, qn, wr_done, last_id} !== {4'b0000, 8'h00, 8'hFF, 1'b0, 2'd3}) begin
      miscompares++;
      $display("FAIL async_reset: got gnt=%b q=%h qn=%h done=%b id=%0d, need 0000 00 ff 0 3",
               gnt, q, qn, wr_done, last_id);
    end
    #1;
    rst = 1'b0;
    model_reset();
    req = 4'b1111;
    cycle();
    req = 4'b0000;
    vectors++;
    if ({gnt, q, last_id} !== {4'b0001, 8'h00, 2'd0}) begin
      miscompares++;
      $display("FAIL async_rearb: got gnt=%b q=%h id=%0d, need 0001 00 0", gnt, q, last_id);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req   = 4'($urandom_range(15, 0));
      wdata = $urandom();
      clr   = ($urandom_range(9, 0) == 0);
      cycle();
      vectors++;
      if ({gnt, q, qn, wr_done, last_id} !== {m_gnt, m_q, ~m_q, m_done, 2'(m_last)}) begin
        miscompares++;
        $display("FAIL random[%0d]: got gnt=%b q=%h qn=%h done=%b id=%0d, need %b %h %h %b %0d",
                 k, gnt, q, qn, wr_done, last_id, m_gnt, m_q, ~m_q, m_done, m_last);
      end
    end
    clr = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_write();
    test_contention();
    test_masking();
    test_clr_grant();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
